// File: rtl/spi_sensor_master.sv
// SPI mode-0 initiator: shifts out a CMD_W-bit command, then captures a DATA_W-bit sample.
// Define AUTO_TRIGGER_EN to add a free-running timer that launches a read every SAMPLE_PER cycles.
module spi_sensor_master #(
    parameter int CLK_DIV    = 2,
    parameter int CMD_W      = 8,
    parameter int DATA_W     = 16,
    parameter int SAMPLE_PER = 10000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CMD_W-1:0]  cmd,
    output logic              busy,
    output logic              sensor_sck,
    output logic              sensor_cs,
    output logic              sensor_mosi,
    input  logic              sensor_miso,
    output logic [DATA_W-1:0] data_out,
    output logic              data_ready
);
    localparam int PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(CMD_W + DATA_W + 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CMD_W + DATA_W);
    localparam logic [BIT_W-1:0] BIT_CMD  = BIT_W'(CMD_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state;
    logic [PH_W-1:0]   r_phase;
    logic [PH_W-1:0]   w_phase;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [BIT_W-1:0]  w_bit_cnt;
    logic [CMD_W-1:0]  r_cmd_sr;
    logic [CMD_W-1:0]  w_cmd_sr;
    logic [DATA_W-1:0] r_rx_sr;
    logic [DATA_W-1:0] w_rx_sr;
    logic [DATA_W-1:0] r_data_out;
    logic [DATA_W-1:0] w_data_out;
    logic              r_sck;
    logic              w_sck;
    logic              r_cs;
    logic              w_cs;
    logic              r_mosi;
    logic              w_mosi;
    logic              r_busy;
    logic              w_busy;
    logic              r_data_ready;
    logic              w_data_ready;
    logic              w_phase_end;
    logic              w_launch;

`ifdef AUTO_TRIGGER_EN
    localparam int TMR_W = (SAMPLE_PER > 1) ? $clog2(SAMPLE_PER) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_PER - 1);

    logic [TMR_W-1:0] r_timer;
    logic             w_trigger;

    // Free-running sample timer; its wrap cycle is the auto-trigger.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
        end else if (r_timer == TMR_LAST) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TMR_W'(1);
        end
    end

    assign w_trigger = (r_timer == TMR_LAST);
    assign w_launch  = start | w_trigger;
`else
    assign w_launch  = start;
`endif

    assign w_phase_end = (r_phase == PH_LAST);

    // Next-state and datapath decode; each half SCK period ends on w_phase_end.
    always_comb begin
        w_state      = r_state;
        w_phase      = r_phase;
        w_bit_cnt    = r_bit_cnt;
        w_cmd_sr     = r_cmd_sr;
        w_rx_sr      = r_rx_sr;
        w_data_out   = r_data_out;
        w_sck        = r_sck;
        w_cs         = r_cs;
        w_mosi       = r_mosi;
        w_busy       = r_busy;
        w_data_ready = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_phase   = '0;
                w_bit_cnt = '0;
                if (w_launch) begin
                    w_state  = S_SETUP;
                    w_cs     = 1'b0;
                    w_busy   = 1'b1;
                    w_mosi   = cmd[CMD_W-1];
                    w_cmd_sr = {cmd[CMD_W-2:0], 1'b0};
                end else begin
                    w_state  = S_IDLE;
                end
            end
            S_SETUP: begin
                if (w_phase_end) begin
                    // First rising edge always lands on a command bit, so MISO is not kept.
                    w_state   = S_SHIFT;
                    w_phase   = '0;
                    w_sck     = 1'b1;
                    w_bit_cnt = r_bit_cnt + BIT_W'(1);
                end else begin
                    w_phase   = r_phase + PH_W'(1);
                end
            end
            S_SHIFT: begin
                if (!w_phase_end) begin
                    w_phase = r_phase + PH_W'(1);
                end else if (r_sck) begin
                    // Falling edge: the command register zero-fills, so MOSI drops to 0 after the command.
                    w_phase  = '0;
                    w_sck    = 1'b0;
                    w_mosi   = r_cmd_sr[CMD_W-1];
                    w_cmd_sr = {r_cmd_sr[CMD_W-2:0], 1'b0};
                end else if (r_bit_cnt == BIT_LAST) begin
                    w_state = S_HOLD;
                    w_phase = '0;
                end else begin
                    w_phase   = '0;
                    w_sck     = 1'b1;
                    w_bit_cnt = r_bit_cnt + BIT_W'(1);
                    if (r_bit_cnt >= BIT_CMD) begin
                        w_rx_sr = {r_rx_sr[DATA_W-2:0], sensor_miso};
                    end else begin
                        w_rx_sr = r_rx_sr;
                    end
                end
            end
            S_HOLD: begin
                if (w_phase_end) begin
                    w_state      = S_GAP;
                    w_phase      = '0;
                    w_cs         = 1'b1;
                    w_data_out   = r_rx_sr;
                    w_data_ready = 1'b1;
                end else begin
                    w_phase      = r_phase + PH_W'(1);
                end
            end
            S_GAP: begin
                if (w_phase_end) begin
                    w_state = S_IDLE;
                    w_phase = '0;
                    w_busy  = 1'b0;
                end else begin
                    w_phase = r_phase + PH_W'(1);
                end
            end
            default: begin
                w_state   = S_IDLE;
                w_phase   = '0;
                w_bit_cnt = '0;
                w_sck     = 1'b0;
                w_cs      = 1'b1;
                w_mosi    = 1'b0;
                w_busy    = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transfer and discards the partial sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_phase      <= '0;
            r_bit_cnt    <= '0;
            r_cmd_sr     <= '0;
            r_rx_sr      <= '0;
            r_data_out   <= '0;
            r_sck        <= 1'b0;
            r_cs         <= 1'b1;
            r_mosi       <= 1'b0;
            r_busy       <= 1'b0;
            r_data_ready <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_phase      <= w_phase;
            r_bit_cnt    <= w_bit_cnt;
            r_cmd_sr     <= w_cmd_sr;
            r_rx_sr      <= w_rx_sr;
            r_data_out   <= w_data_out;
            r_sck        <= w_sck;
            r_cs         <= w_cs;
            r_mosi       <= w_mosi;
            r_busy       <= w_busy;
            r_data_ready <= w_data_ready;
        end
    end

    assign busy        = r_busy;
    assign sensor_sck  = r_sck;
    assign sensor_cs   = r_cs;
    assign sensor_mosi = r_mosi;
    assign data_out    = r_data_out;
    assign data_ready  = r_data_ready;

endmodule

// File: tb/tb_spi_sensor_master.sv
// Scoreboard bench for spi_sensor_master: three instances at CLK_DIV 2, 1 and 5 run side by side,
// each with a mode-0 sensor model, a transaction-level timing model and a decoupled monitor.
module tb_spi_sensor_master;
    localparam int CMD_W  = 8;
    localparam int DATA_W = 16;
    localparam int NBITS  = CMD_W + DATA_W;

    typedef struct {
        int                cycle;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input int div, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL div%0d %s: got %0h, expected %0h (cycle %0d)", div, name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_lane
        localparam int CD      = (g == 0) ? 2 : ((g == 1) ? 1 : 5);
        // Acceptance cycle -> data_ready cycle, and -> first cycle with busy low again.
        localparam int T_READY = 1 + CD * (2 * NBITS + 2);
        localparam int T_IDLE  = 1 + CD * (2 * NBITS + 3);

        logic              rst = 1'b1;
        logic              start = 1'b0;
        logic [CMD_W-1:0]  cmd = '0;
        logic              miso = 1'b0;
        logic              busy;
        logic              sck;
        logic              cs;
        logic              mosi;
        logic [DATA_W-1:0] dout;
        logic              ready;

        exp_t              exp_q[$];
        int                busy_from = 0;
        int                busy_to = 0;
        logic [CMD_W-1:0]  slave_cmd = '0;
        logic [DATA_W-1:0] slave_data = '0;
        bit                fin = 1'b0;

        spi_sensor_master #(
            .CLK_DIV    (CD),
            .CMD_W      (CMD_W),
            .DATA_W     (DATA_W),
            .SAMPLE_PER (10000)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .start       (start),
            .cmd         (cmd),
            .busy        (busy),
            .sensor_sck  (sck),
            .sensor_cs   (cs),
            .sensor_mosi (mosi),
            .sensor_miso (miso),
            .data_out    (dout),
            .data_ready  (ready)
        );

        // Sensor model: records MOSI on SCK rises, drives MISO after SCK falls (noise during the command).
        int               rises = 0;
        int               falls = 0;
        logic [NBITS-1:0] mosi_cap = '0;
        logic             s_cs = 1'b1;
        logic             s_sck = 1'b0;
        always @(cs or sck) begin
            if (s_cs === 1'b1 && cs === 1'b0) begin
                rises = 0;
                falls = 0;
                mosi_cap = '0;
                miso = 1'($urandom);
            end
            if (s_sck === 1'b0 && sck === 1'b1 && cs === 1'b0) begin
                mosi_cap = {mosi_cap[NBITS-2:0], mosi};
                rises++;
            end
            if (s_sck === 1'b1 && sck === 1'b0 && cs === 1'b0) begin
                falls++;
                if (falls >= CMD_W && falls < NBITS) miso = slave_data[NBITS-1-falls];
                else miso = 1'($urandom);
            end
            if (s_cs === 1'b0 && cs === 1'b1 && rst === 1'b0) begin
                chk(rises == NBITS, CD, "sck rising edges", rises, NBITS);
                chk(mosi_cap[NBITS-1 -: CMD_W] === slave_cmd, CD, "mosi command",
                    int'(mosi_cap[NBITS-1 -: CMD_W]), int'(slave_cmd));
                chk(mosi_cap[DATA_W-1:0] === '0, CD, "mosi after command", int'(mosi_cap[DATA_W-1:0]), 0);
            end
            s_cs = cs;
            s_sck = sck;
        end

        // Monitor: pops the scoreboard on data_ready, tracks busy/data_out and SCK/CS timing.
        int   t_cs_fall = 0;
        int   t_cs_rise = -1;
        int   t_rise = 0;
        int   t_fall = 0;
        int   nrise = 0;
        logic p_cs = 1'b1;
        logic p_sck = 1'b0;
        logic [DATA_W-1:0] held = '0;
        always @(negedge clk) begin
            bit exp_rdy;
            bit exp_busy;
            if (rst) begin
                exp_q.delete();
                held = '0;
                p_cs = cs;
                p_sck = sck;
                nrise = 0;
                t_cs_rise = -1;
            end else begin
                while (exp_q.size() > 0 && exp_q[0].cycle < cyc) void'(exp_q.pop_front());
                exp_rdy = (exp_q.size() > 0) && (exp_q[0].cycle == cyc);
                chk(ready === exp_rdy, CD, "data_ready", int'(ready), int'(exp_rdy));
                if (exp_rdy) begin
                    held = exp_q[0].data;
                    void'(exp_q.pop_front());
                end
                chk(dout === held, CD, "data_out", int'(dout), int'(held));
                exp_busy = (cyc >= busy_from) && (cyc < busy_to);
                chk(busy === exp_busy, CD, "busy", int'(busy), int'(exp_busy));
                if (p_cs === 1'b1 && cs === 1'b0) begin
                    if (t_cs_rise >= 0) chk(cyc - t_cs_rise >= CD, CD, "cs high time", cyc - t_cs_rise, CD);
                    t_cs_fall = cyc;
                    nrise = 0;
                end
                if (p_sck === 1'b0 && sck === 1'b1) begin
                    if (nrise == 0) chk(cyc - t_cs_fall == CD, CD, "cs-low to first rise", cyc - t_cs_fall, CD);
                    else chk(cyc - t_fall == CD, CD, "sck low time", cyc - t_fall, CD);
                    t_rise = cyc;
                    nrise++;
                end
                if (p_sck === 1'b1 && sck === 1'b0) begin
                    chk(cyc - t_rise == CD, CD, "sck high time", cyc - t_rise, CD);
                    t_fall = cyc;
                end
                if (p_cs === 1'b0 && cs === 1'b1) begin
                    // Final low half-period plus HOLD: cs rises CLK_DIV after that half-period ends.
                    chk(cyc - t_fall == 2 * CD, CD, "last fall to cs high", cyc - t_fall, 2 * CD);
                    t_cs_rise = cyc;
                end
                p_cs = cs;
                p_sck = sck;
            end
        end

        task automatic step(input int n);
            repeat (n) begin
                @(posedge clk);
                #1;
                cmd = CMD_W'($urandom);
            end
        endtask

        task automatic to_cycle(input int c);
            while (cyc < c) step(1);
        endtask

        // One-cycle start pulse; the model decides acceptance and queues the expected sample.
        task automatic pulse(input logic [CMD_W-1:0] c, input logic [DATA_W-1:0] d, output bit acc);
            exp_t e;
            start = 1'b1;
            cmd = c;
            acc = (cyc >= busy_to);
            if (acc) begin
                busy_from = cyc + 1;
                busy_to = cyc + T_IDLE;
                slave_cmd = c;
                slave_data = d;
                e.cycle = cyc + T_READY;
                e.data = d;
                exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        endtask

        initial begin
            bit acc;
            int t0;
            int n_acc;
            repeat (3) @(posedge clk);
            #1;
            chk(cs === 1'b1, CD, "reset cs", int'(cs), 1);
            chk(sck === 1'b0, CD, "reset sck", int'(sck), 0);
            chk(mosi === 1'b0, CD, "reset mosi", int'(mosi), 0);
            chk(busy === 1'b0, CD, "reset busy", int'(busy), 0);
            chk(dout === '0, CD, "reset data_out", int'(dout), 0);
            chk(ready === 1'b0, CD, "reset data_ready", int'(ready), 0);
            rst = 1'b0;
            step(2);

            pulse(8'hA8, 16'hBEEF, acc);
            t0 = busy_from - 1;
            to_cycle(t0 + 10);
            pulse(CMD_W'($urandom), DATA_W'($urandom), acc);
            to_cycle(t0 + 50);
            pulse(CMD_W'($urandom), DATA_W'($urandom), acc);
            to_cycle(busy_to);
            pulse(8'h3C, 16'h1234, acc);

            to_cycle(busy_to);
            pulse(8'h81, 16'h0000, acc);
            to_cycle(busy_to);
            pulse(8'h7E, 16'hFFFF, acc);

            n_acc = 0;
            for (int i = 0; i < 5000 && n_acc < 6; i++) begin
                if ($urandom_range(15, 0) == 0) begin
                    pulse(CMD_W'($urandom), DATA_W'($urandom), acc);
                    if (acc) n_acc++;
                end else begin
                    step(1);
                end
            end

            to_cycle(busy_to);
            pulse(8'hA5, 16'h5A5A, acc);
            step(11 * CD);
            rst = 1'b1;
            #1;
            chk(cs === 1'b1, CD, "abort cs", int'(cs), 1);
            chk(sck === 1'b0, CD, "abort sck", int'(sck), 0);
            chk(mosi === 1'b0, CD, "abort mosi", int'(mosi), 0);
            chk(busy === 1'b0, CD, "abort busy", int'(busy), 0);
            chk(dout === '0, CD, "abort data_out", int'(dout), 0);
            chk(ready === 1'b0, CD, "abort data_ready", int'(ready), 0);
            busy_from = 0;
            busy_to = 0;
            step(2);
            rst = 1'b0;
            step(3);

            pulse(8'hC3, DATA_W'($urandom), acc);
            to_cycle(busy_to + 3);
            chk(exp_q.size() == 0, CD, "pending data_ready", exp_q.size(), 0);
            fin = 1'b1;
        end
    end

    initial begin
        int  n;
        bit  all_fin;
        n = 0;
        all_fin = 1'b0;
        while (n < 60000 && !all_fin) begin
            @(posedge clk);
            n++;
            all_fin = g_lane[0].fin && g_lane[1].fin && g_lane[2].fin;
        end
        chk(all_fin, 0, "lanes completed within budget", int'(all_fin), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
